seq_sequencer: RTL and testbench

Phase sequencer and PC controller for the sequential Y86-64 core. It steps one instruction at a time through fetch, decode, execute, memory and writeback+PC-update, asserting exactly one stage enable per cycle. It selects the next PC from the fetch, execute and memory results. It holds the architectural status code and stops the core on halt, address error or invalid instruction.

---
 rtl/seq_sequencer.sv | 87 ++++++++
 tb/tb_seq_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_sequencer.sv
// seq_sequencer: Y86-64 phase sequencer/PC controller; in: start, icode/imem_error/inv_instr/cnd/valC/valP/valM/dmem_error; out: PC, f/d/e/m/w_en, stat, busy, halted, cycle_cnt/instr_cnt (live only with SEQ_SEQUENCER_PERF_EN)
module seq_sequencer #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        imem_error,
  input  logic        inv_instr,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  input  logic        dmem_error,
  output logic [63:0] PC,
  output logic        f_en,
  output logic        d_en,
  output logic        e_en,
  output logic        m_en,
  output logic        w_en,
  output logic [2:0]  stat,
  output logic        busy,
  output logic        halted,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, STOP} state_t;
  state_t state_q;
  logic [63:0] pc_q, pc_d;
  logic [2:0] stat_q;
  logic fault;
  assign fault = imem_error | inv_instr | (icode == 4'd0);
  assign pc_d = (icode == 4'd8 || (icode == 4'd7 && cnd)) ? valC : (icode == 4'd9) ? valM : valP;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      stat_q <= 3'd1;
    end else begin
      case (state_q)
        IDLE: if (start) state_q <= FETCH;
        FETCH: state_q <= DECODE;
        DECODE: begin
          state_q <= fault ? STOP : EXECUTE;
          if (fault) stat_q <= imem_error ? 3'd3 : inv_instr ? 3'd4 : 3'd2;
        end
        EXECUTE: state_q <= MEMORY;
        MEMORY: state_q <= WRITEBACK;
        WRITEBACK: begin
          state_q <= dmem_error ? STOP : FETCH;
          if (dmem_error) stat_q <= 3'd3;
          else pc_q <= pc_d;
        end
        default: state_q <= state_q;
      endcase
    end
  end
  assign PC = pc_q;
  assign stat = stat_q;
  assign f_en = state_q == FETCH;
  assign d_en = state_q == DECODE && !fault;
  assign e_en = state_q == EXECUTE;
  assign m_en = state_q == MEMORY;
  assign w_en = state_q == WRITEBACK && !dmem_error;
  assign busy = state_q inside {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK};
  assign halted = state_q == STOP;
`ifdef SEQ_SEQUENCER_PERF_EN
  logic [31:0] cyc_q, ins_q;
  logic retire;
  assign retire = w_en || (state_q == DECODE && !imem_error && !inv_instr && icode == 4'd0);
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (busy && cyc_q != '1) cyc_q <= cyc_q + 32'd1;
      if (retire && ins_q != '1) ins_q <= ins_q + 32'd1;
    end
  end
  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_sequencer.sv
// tb_seq_sequencer: directed self-checking bench for seq_sequencer
module tb_seq_sequencer;
`ifdef SEQ_SEQUENCER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [3:0] icode = 4'd1;
  logic imem_error = 1'b0, inv_instr = 1'b0, cnd = 1'b0, dmem_error = 1'b0;
  logic [63:0] valC = '0, valP = '0, valM = '0, PC;
  logic f_en, d_en, e_en, m_en, w_en, busy, halted;
  logic [2:0] stat;
  logic [31:0] cycle_cnt, instr_cnt;
  int n_chk = 0, n_fail = 0;
  seq_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .imem_error(imem_error),
    .inv_instr(inv_instr), .cnd(cnd), .valC(valC), .valP(valP), .valM(valM),
    .dmem_error(dmem_error), .PC(PC), .f_en(f_en), .d_en(d_en), .e_en(e_en),
    .m_en(m_en), .w_en(w_en), .stat(stat), .busy(busy), .halted(halted),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [4:0] en();
    return {f_en, d_en, e_en, m_en, w_en};
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    icode = 4'd1;
    {imem_error, inv_instr, cnd, dmem_error} = '0;
    tick();
    rst = 1'b0;
    chk("rst_en", {59'd0, en()}, 64'd0);
    chk("rst_pc", PC, 64'd0);
    chk("rst_stat", {61'd0, stat}, 64'd1);
    chk("rst_busy_halt", {62'd0, busy, halted}, 64'd0);
    chk("rst_cnt", {cycle_cnt, instr_cnt}, 64'd0);
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_fen", {59'd0, en()}, 64'b10000);
  endtask
  task automatic do_instr(input logic [3:0] ic, input logic c, input logic [63:0] vc,
                          input logic [63:0] vp, input logic [63:0] vm, input logic [63:0] exp_pc);
    logic [63:0] pc0;
    pc0 = PC;
    icode = ic;
    cnd = c;
    valC = vc;
    valP = vp;
    valM = vm;
    chk("i_f", {59'd0, en()}, 64'b10000);
    tick();
    chk("i_d", {59'd0, en()}, 64'b01000);
    tick();
    chk("i_e", {59'd0, en()}, 64'b00100);
    tick();
    chk("i_m", {59'd0, en()}, 64'b00010);
    tick();
    chk("i_w", {59'd0, en()}, 64'b00001);
    chk("i_pc_hold", PC, pc0);
    tick();
    chk("i_f_next", {59'd0, en()}, 64'b10000);
    chk("i_pc", PC, exp_pc);
    chk("i_stat", {61'd0, stat}, 64'd1);
  endtask
  task automatic do_fault(input logic [3:0] ic, input logic ie, input logic iv,
                          input logic [2:0] exp_stat, input logic [63:0] exp_pc);
    icode = ic;
    imem_error = ie;
    inv_instr = iv;
    tick();
    chk("flt_d", {59'd0, en()}, 64'd0);
    chk("flt_busy", {63'd0, busy}, 64'd1);
    tick();
    imem_error = 1'b0;
    inv_instr = 1'b0;
    icode = 4'd1;
    chk("flt_stat", {61'd0, stat}, {61'd0, exp_stat});
    chk("flt_halted", {62'd0, busy, halted}, 64'b01);
    chk("flt_pc", PC, exp_pc);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("stop_en", {59'd0, en()}, 64'd0);
    chk("stop_halted", {63'd0, halted}, 64'd1);
    chk("stop_stat", {61'd0, stat}, {61'd0, exp_stat});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    tick();
    do_reset();
    tick();
    chk("idle_en", {59'd0, en()}, 64'd0);
    do_start();
    do_instr(4'd3, 1'b0, 64'd0, 64'd10, 64'd0, 64'd10);
    do_instr(4'd7, 1'b1, 64'd39, 64'd5, 64'd0, 64'd39);
    do_instr(4'd7, 1'b0, 64'd77, 64'd9, 64'd0, 64'd9);
    do_fault(4'd0, 1'b0, 1'b0, 3'd2, 64'd9);
    chk("perf_cyc", {32'd0, cycle_cnt}, PERF ? 64'd17 : 64'd0);
    chk("perf_ins", {32'd0, instr_cnt}, PERF ? 64'd4 : 64'd0);
    do_reset();
    do_start();
    do_instr(4'd8, 1'b0, 64'h100, 64'd9, 64'd0, 64'h100);
    do_instr(4'd9, 1'b0, 64'd3, 64'd9, 64'h40, 64'h40);
    do_fault(4'd0, 1'b1, 1'b1, 3'd3, 64'h40);
    chk("adr_ins", {32'd0, instr_cnt}, PERF ? 64'd2 : 64'd0);
    do_reset();
    do_start();
    do_fault(4'd5, 1'b0, 1'b1, 3'd4, 64'd0);
    do_reset();
    do_start();
    do_instr(4'd3, 1'b0, 64'd0, 64'd10, 64'd0, 64'd10);
    icode = 4'd6;
    valP = 64'd20;
    tick();
    tick();
    tick();
    dmem_error = 1'b1;
    tick();
    chk("dmem_wen", {59'd0, en()}, 64'd0);
    tick();
    dmem_error = 1'b0;
    chk("dmem_stat", {61'd0, stat}, 64'd3);
    chk("dmem_pc", PC, 64'd10);
    chk("dmem_halted", {63'd0, halted}, 64'd1);
    chk("dmem_ins", {32'd0, instr_cnt}, PERF ? 64'd1 : 64'd0);
    do_reset();
    do_start();
    do_instr(4'd7, 1'b1, 64'd39, 64'd2, 64'd0, 64'd39);
    icode = 4'd6;
    tick();
    tick();
    chk("mid_e", {59'd0, en()}, 64'b00100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_en", {59'd0, en()}, 64'd0);
    chk("mid_pc", PC, 64'd0);
    chk("mid_stat", {61'd0, stat}, 64'd1);
    chk("mid_busy", {62'd0, busy, halted}, 64'd0);
    chk("mid_cnt", {cycle_cnt, instr_cnt}, 64'd0);
    tick();
    tick();
    tick();
    chk("mid_idle_en", {59'd0, en()}, 64'd0);
    do_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
